// File: rtl/boot_copier_pkg.sv
// Shared types and helpers for the boot image copier.
// Holds the FSM state encoding and the word-to-byte address mapping.
package boot_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [31:0] BYTES_PER_WORD = 32'd4;

  // Byte address of word idx relative to base, wrapping at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/boot_copier_timeout.sv
// Bus wait watchdog: counts stalled cycles and flags expiry at TIMEOUT-1.
// Clear has priority over enable; the count saturates once expired.
module bus_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/boot_copier.sv
// Copies WORD_COUNT words from boot ROM to RAM, 6 cycles/word with single-cycle responders.
// Each request is held until its ready is sampled; a stall of TIMEOUT cycles aborts to ERROR.
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0001_0000,
  parameter int unsigned WORD_COUNT = 33,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_rom_request,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_rdata,
  input  logic        i_rom_ready,
  output logic        o_ram_request,
  output logic        o_ram_rw,
  output logic [31:0] o_ram_address,
  output logic [31:0] o_ram_wdata,
  input  logic        i_ram_ready
);

  localparam int IDX_W = (WORD_COUNT > 0) ? $clog2(WORD_COUNT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      buf_q;
  logic             rom_req_q, ram_req_q;
  logic [31:0]      rom_addr_q, ram_addr_q, wdata_q;
  logic             busy_q, done_q, error_q;
  logic             tmo_clear, tmo_en, tmo_expired;

  // The watchdog only runs while a request is outstanding; every other state rearms it.
  assign tmo_clear = !((state_q == ST_RD) || (state_q == ST_WR));
  assign tmo_en    = ((state_q == ST_RD) && !i_rom_ready) || ((state_q == ST_WR) && !i_ram_ready);

  bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .clear_i  (tmo_clear),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      rom_req_q  <= 1'b0;
      ram_req_q  <= 1'b0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (i_start) begin
            error_q <= 1'b0;
            idx_q   <= '0;
            if (WORD_COUNT == 0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RD;
              rom_req_q  <= 1'b1;
              rom_addr_q <= word_addr(SRC_BASE, 32'd0);
              busy_q     <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (i_rom_ready) begin
            buf_q     <= i_rom_rdata;
            rom_req_q <= 1'b0;
            state_q   <= ST_RD_GAP;
          end else if (tmo_expired) begin
            rom_req_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b1;
            state_q   <= ST_ERROR;
          end
        end
        // A ready still high from the read is deliberately not looked at here.
        ST_RD_GAP: begin
          state_q    <= ST_WR;
          ram_req_q  <= 1'b1;
          ram_addr_q <= word_addr(DST_BASE, 32'(idx_q));
          wdata_q    <= buf_q;
        end
        ST_WR: begin
          if (i_ram_ready) begin
            ram_req_q <= 1'b0;
            state_q   <= ST_WR_GAP;
          end else if (tmo_expired) begin
            ram_req_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b1;
            state_q   <= ST_ERROR;
          end
        end
        ST_WR_GAP: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q      <= idx_q + IDX_W'(1);
            state_q    <= ST_RD;
            rom_req_q  <= 1'b1;
            rom_addr_q <= word_addr(SRC_BASE, 32'(idx_q) + 32'd1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_rom_request = rom_req_q;
  assign o_rom_address = rom_addr_q;
  assign o_ram_request = ram_req_q;
  assign o_ram_rw      = 1'b1;
  assign o_ram_address = ram_addr_q;
  assign o_ram_wdata   = wdata_q;

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench: main copier (TIMEOUT=16) on ROM/RAM responder models, plus a zero-word instance.
module tb_boot_copier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic        rom_req, ram_req, ram_rw;
  logic [31:0] rom_addr, ram_addr, ram_wdata;
  logic [31:0] rom_rdata = 32'd0;
  logic        rom_ready = 1'b0;
  logic        ram_ready = 1'b0;

  logic        start0 = 1'b0;
  logic        busy0, done0, error0, rom_req0, ram_req0, ram_rw0;
  logic [31:0] rom_addr0, ram_addr0, ram_wdata0;
  logic [31:0] rom_rdata0 = 32'd0;
  logic        rom_ready0 = 1'b0;
  logic        ram_ready0 = 1'b0;

  int tests = 0;
  int fails = 0;

  // Responder models and monitors
  logic [31:0] mem [64];
  int wr_count = 0, bad_wr = 0, rom_wait = 0;
  int rom_delay_word = -1, rom_delay_cycles = 0, rom_hang_word = -1;
  int stab_err = 0, watch_cnt = 0, done_cnt = 0, zero_bus = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  logic        rom_req_p = 1'b0, ram_req_p = 1'b0;
  logic [31:0] rom_addr_p = 32'd0, ram_addr_p = 32'd0, ram_wdata_p = 32'd0;

  always #5 clk = ~clk;

  boot_copier #(
    .TIMEOUT(16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_rom_request(rom_req),
    .o_rom_address(rom_addr),
    .i_rom_rdata  (rom_rdata),
    .i_rom_ready  (rom_ready),
    .o_ram_request(ram_req),
    .o_ram_rw     (ram_rw),
    .o_ram_address(ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_ready  (ram_ready)
  );

  boot_copier #(
    .WORD_COUNT(0)
  ) dut0 (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start0),
    .o_busy       (busy0),
    .o_done       (done0),
    .o_error      (error0),
    .o_rom_request(rom_req0),
    .o_rom_address(rom_addr0),
    .i_rom_rdata  (rom_rdata0),
    .i_rom_ready  (rom_ready0),
    .o_ram_request(ram_req0),
    .o_ram_rw     (ram_rw0),
    .o_ram_address(ram_addr0),
    .o_ram_wdata  (ram_wdata0),
    .i_ram_ready  (ram_ready0)
  );

  always @(posedge clk) begin
    if (rom_req && !rom_ready) begin
      if (int'(rom_addr >> 2) == rom_hang_word) begin
        rom_ready <= 1'b0;
      end else if (int'(rom_addr >> 2) == rom_delay_word && rom_wait < rom_delay_cycles) begin
        rom_wait = rom_wait + 1;
        rom_ready <= 1'b0;
      end else begin
        rom_wait = 0;
        rom_ready <= 1'b1;
        rom_rdata <= 32'h1000 + (rom_addr >> 2);
      end
    end else begin
      rom_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (ram_req && !ram_ready) begin
      ram_ready <= 1'b1;
      if (ram_rw === 1'b1 && ram_addr >= 32'h0001_0000 && ram_addr < 32'h0001_0100)
        mem[ram_addr[7:2]] = ram_wdata;
      else
        bad_wr = bad_wr + 1;
      wr_count = wr_count + 1;
    end else begin
      ram_ready <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rom_req === 1'b1 && rom_req_p && rom_addr !== rom_addr_p) stab_err = stab_err + 1;
    if (ram_req === 1'b1 && ram_req_p && (ram_addr !== ram_addr_p || ram_wdata !== ram_wdata_p))
      stab_err = stab_err + 1;
    if (rom_req === 1'b1 && rom_addr === watch_addr) watch_cnt = watch_cnt + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (rom_req0 === 1'b1 || ram_req0 === 1'b1) zero_bus = zero_bus + 1;
    rom_req_p   = (rom_req === 1'b1);
    ram_req_p   = (ram_req === 1'b1);
    rom_addr_p  = rom_addr;
    ram_addr_p  = ram_addr;
    ram_wdata_p = ram_wdata;
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
    wr_count = 0;
    bad_wr   = 0;
  endtask

  // Called just after a negedge; returns just after the negedge following start edge E0.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns k where done was seen in the cycle after edge E0+k, or -1 past the budget.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) cycles = -1;
  endtask

  task automatic check_image(input string name);
    tests++;
    if (wr_count !== 33 || bad_wr !== 0) begin
      fails++;
      $display("FAIL %s writes: got %0d (bad %0d), want 33 (bad 0)", name, wr_count, bad_wr);
    end
    for (int i = 0; i < 33; i++) begin
      tests++;
      if (mem[i] !== 32'h1000 + 32'(i)) begin
        fails++;
        $display("FAIL %s word %0d: got %h, want %h", name, i, mem[i], 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, error, rom_req, ram_req, ram_rw} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_flags: got %b, want 000001", {busy, done, error, rom_req, ram_req, ram_rw});
    end
    tests++;
    if (rom_addr !== 32'd0 || ram_addr !== 32'd0 || ram_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_buses: got %h %h %h, want 0 0 0", rom_addr, ram_addr, ram_wdata);
    end
    tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || error0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_zero_inst: got %b%b%b, want 000", done0, busy0, error0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy();
    int cyc, d0;
    clear_mem();
    stab_err = 0;
    d0 = done_cnt;
    pulse_start();
    tests++;
    if (rom_req !== 1'b1 || rom_addr !== 32'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL copy_first_req: got req=%b addr=%h busy=%b, want 1 0 1", rom_req, rom_addr, busy);
    end
    wait_done(400, cyc);
    tests++;
    if (cyc !== 198) begin
      fails++;
      $display("FAIL copy_latency: got %0d, want 198", cyc);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL copy_after_done: got done=%b busy=%b pulses=%0d, want 0 0 1", done, busy, done_cnt - d0);
    end
    check_image("copy");
  endtask

  task automatic test_rom_delay();
    int cyc;
    clear_mem();
    stab_err = 0;
    watch_cnt = 0;
    watch_addr = 32'h14;
    rom_delay_word = 5;
    rom_delay_cycles = 3;
    pulse_start();
    wait_done(400, cyc);
    tests++;
    if (cyc !== 201) begin
      fails++;
      $display("FAIL delay_latency: got %0d, want 201", cyc);
    end
    tests++;
    if (watch_cnt !== 5 || stab_err !== 0) begin
      fails++;
      $display("FAIL delay_hold: got %0d req cycles stab_err=%0d, want 5 and 0", watch_cnt, stab_err);
    end
    check_image("delay");
    rom_delay_word = -1;
    watch_addr = 32'hFFFF_FFFF;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    clear_mem();
    watch_cnt = 0;
    watch_addr = 32'h8;
    rom_hang_word = 2;
    pulse_start();
    cyc = 0;
    while (error !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    tests++;
    if (error !== 1'b1 || rom_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_state: got err=%b req=%b busy=%b, want 1 0 0", error, rom_req, busy);
    end
    tests++;
    if (watch_cnt !== 16) begin
      fails++;
      $display("FAIL timeout_req_cycles: got %0d, want 16", watch_cnt);
    end
    tests++;
    if (wr_count !== 2) begin
      fails++;
      $display("FAIL timeout_writes: got %0d, want 2", wr_count);
    end
    rom_hang_word = -1;
    watch_addr = 32'hFFFF_FFFF;
    clear_mem();
    pulse_start();
    tests++;
    if (error !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 32'd0) begin
      fails++;
      $display("FAIL timeout_restart: got err=%b req=%b addr=%h, want 0 1 0", error, rom_req, rom_addr);
    end
    wait_done(400, cyc);
    tests++;
    if (cyc !== 198) begin
      fails++;
      $display("FAIL timeout_recopy_latency: got %0d, want 198", cyc);
    end
    check_image("recopy");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, snap;
    clear_mem();
    pulse_start();
    cyc = 0;
    while (!(ram_req === 1'b1 && ram_addr === 32'h0001_0028) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc >= 200) begin
      fails++;
      $display("FAIL midreset_reach_wr10: got timeout after %0d cycles, want WR of word 10", cyc);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rom_req !== 1'b0 || ram_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got rom=%b ram=%b busy=%b, want 0 0 0", rom_req, ram_req, busy);
    end
    snap = wr_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (wr_count !== snap || ram_req !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_writes: got %0d writes req=%b, want %0d and 0", wr_count, ram_req, snap);
    end
    clear_mem();
    pulse_start();
    tests++;
    if (rom_addr !== 32'd0 || rom_req !== 1'b1) begin
      fails++;
      $display("FAIL midreset_restart_addr: got %h req=%b, want 0 1", rom_addr, rom_req);
    end
    wait_done(400, cyc);
    tests++;
    if (cyc !== 198) begin
      fails++;
      $display("FAIL midreset_latency: got %0d, want 198", cyc);
    end
    check_image("after_reset");
    @(negedge clk);
  endtask

  task automatic test_zero_words();
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    tests++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL zero_done: got done=%b busy=%b, want 1 0", done0, busy0);
    end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL zero_done_width: got %b, want 0", done0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (zero_bus !== 0 || ram_rw0 !== 1'b1) begin
      fails++;
      $display("FAIL zero_no_bus: got %0d request cycles rw=%b, want 0 1", zero_bus, ram_rw0);
    end
  endtask

  task automatic test_start_held();
    int cyc, d0;
    clear_mem();
    watch_cnt = 0;
    watch_addr = 32'd0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(400, cyc);
    start = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (cyc !== 198) begin
      fails++;
      $display("FAIL held_latency: got %0d, want 198", cyc);
    end
    tests++;
    if (done_cnt - d0 !== 1 || watch_cnt !== 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL held_no_restart: got pulses=%0d word0_reqs=%0d busy=%b, want 1 2 0",
               done_cnt - d0, watch_cnt, busy);
    end
    check_image("held");
    watch_addr = 32'hFFFF_FFFF;
  endtask

  initial begin
    test_reset();
    test_copy();
    test_rom_delay();
    test_timeout();
    test_reset_mid();
    test_zero_words();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
